note_seq_classifier: RTL
========================

# note_seq_classifier

Parametrised successor to the fixed five-note adjective/complement/adverb recogniser. It accepts a melody one note per rising edge of `ok` and compares it against three programmable patterns of `LEN` notes. When the melody ends it reports the word class on `tipo`, and it shows the last accepted note on a 7-segment display. It sits between the debounced keypad/switch front end and the top-level game controller.

## Interface
- `LEN`, default 5: notes per sequence; legal range 2–8.
- `PAT_ADJ`, default 15'h58D1 (do,re,mi,fa,sol): adjective pattern, `3*LEN` bits, note 1 in bits [2:0].
- `PAT_COMP`, default 15'h14E5 (sol,fa,mi,re,do): complement pattern.
- `PAT_ADV`, default 15'h1759 (do,mi,sol,mi,do): adverb pattern.
- `TIMEOUT`, default 1000: maximum idle cycles between notes; used only with `TP_TIMEOUT_EN`.

- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `ok` input 1: note-entry strobe, synchronous to `clk`; a note is taken on its rising edge.
- `tom` input 1: tone/octave bit, sampled with each note.
- `nota` input 3: note code; 000 is the error note, 001–111 are do..si.
- `fim` output 1: 1 while in DONE or ERROR.
- `tipo` output 2: 00 invalid, 01 adjective, 10 complement, 11 adverb.
- `display` output 7: {g,f,e,d,c,b,a}, active-high segments.

## Operation
- Edge detection:
  - `ok_q` registers `ok`.
  - `take = ok & ~ok_q`.
  - A held `ok` yields exactly one `take`.
- States:
  - IDLE: `fim`=0, `tipo`=00.
  - COLLECT: `fim`=0, `tipo`=00.
  - DONE: `fim`=1, `tipo`=class.
  - ERROR: `fim`=1, `tipo`=00.
- First note (`take` in IDLE, DONE or ERROR):
  - If `nota`==000 → ERROR.
  - Otherwise latch `tom` into `tom_r` and set index=1.
  - Set match flags `m_adj`/`m_comp`/`m_adv` = (`nota` == pattern note 1).
  - If no flag is set → ERROR; otherwise → COLLECT.
- Subsequent note (`take` in COLLECT):
  - Error note, or `tom` != `tom_r` → ERROR.
  - Otherwise each flag &= (`nota` == pattern[index]) and index increments.
  - All flags clear → ERROR immediately, without waiting for the remaining notes.
  - Index reaches `LEN` with any flag set → DONE.
- Class priority when several flags remain set: adjective > complement > adverb.
- DONE and ERROR hold until the next `take`. That `take` is processed as the first note of a new sequence; no extra press is needed to clear.
- Display (shows the last accepted note, including the note that caused ERROR):
  - do=0x39 (C), re=0x5E (d), mi=0x79 (E), fa=0x71 (F), sol=0x3D (G), la=0x77 (A), si=0x7C (b).
  - Error note, IDLE and reset all show 0x00.
- Index counter width is `$clog2(LEN+1)`. The index never wraps, because DONE is entered at `LEN`.

## Timing
- Reset (asserted low, asynchronous):
  - IDLE, `fim`=0, `tipo`=00, `display`=0x00.
  - `ok_q`=0, index=0, flags=0, `tom_r`=0, timeout counter=0.
- Latency: `ok` sampled high at edge k with `ok_q`=0 → state, `tipo`, `fim` and `display` update at edge k, visible in the cycle after k.
- `ok` held high across many edges: processed once. It must return low for at least one sampled edge before the next note.
- Reset mid-sequence: the sequence is abandoned and no partial result is reported.
- `ok` rising while reset is low: ignored. An `ok` already high when reset releases yields no `take`, because `ok_q` is loaded with it.

## Configuration
- `TP_TIMEOUT_EN` defined:
  - In COLLECT, a counter increments each cycle without `take` and clears on `take`.
  - Count reaching `TIMEOUT` → ERROR.
  - A `take` and expiry in the same cycle: the `take` wins and the counter clears.
- `TP_TIMEOUT_EN` undefined: no counter logic; COLLECT waits indefinitely.

## Test plan
- Default params, `tom`=0, notes 1,2,3,4,5, each `ok` pulse 2 cycles high / 2 low → after fifth edge `fim`=1, `tipo`=01, `display`=0x3D.
- Notes 5,4,3 then 1 → ERROR right after the fourth note: `fim`=1, `tipo`=00, `display`=0x39. Next note 1 restarts: `fim`=0.
- Notes 1,3,5 then 2 → ERROR after the fourth note (adverb flag cleared, others already clear).
- `tom`=1 on note 1, then `tom`=0 on note 2 → ERROR. Separately, `nota`=000 as note 3 → ERROR with `display`=0x00.
- `ok` held high 20 cycles on note 1 → index=1 only. Reset pulsed after note 3 → `fim`=0, `tipo`=00, `display`=0x00 within the reset cycle, and the following notes 1–5 give `tipo`=01.
- With `TP_TIMEOUT_EN`, `TIMEOUT`=8: one note then 8 idle cycles → ERROR. Repeat with `take` on the 8th cycle → stays in COLLECT.

Source files
------------

// File: rtl/note_seq_classifier.sv
// Note-sequence classifier: matches LEN-note melodies against adjective/complement/adverb patterns.
// Optional idle timeout in COLLECT enabled by defining TP_TIMEOUT_EN.
module note_seq_classifier #(
  parameter int unsigned      LEN      = 5,
  parameter logic [3*LEN-1:0] PAT_ADJ  = 15'h58D1,
  parameter logic [3*LEN-1:0] PAT_COMP = 15'h14E5,
  parameter logic [3*LEN-1:0] PAT_ADV  = 15'h1759,
  parameter int unsigned      TIMEOUT  = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ok,
  input  logic       tom,
  input  logic [2:0] nota,
  output logic       fim,
  output logic [1:0] tipo,
  output logic [6:0] display
);

  localparam int unsigned IDX_W = $clog2(LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2,
    S_ERROR   = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_ok_q;
  logic             r_armed;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [2:0]       r_match, w_match_nxt;  // {adv, comp, adj}
  logic             r_tom, w_tom_nxt;
  logic             r_fim, w_fim_nxt;
  logic [1:0]       r_tipo, w_tipo_nxt;
  logic [6:0]       r_display, w_display_nxt;
  logic             w_take;
  logic [2:0]       w_note_adj, w_note_comp, w_note_adv;

`ifdef TP_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
`endif

  function automatic logic [6:0] seg7(input logic [2:0] n);
    case (n)
      3'd1:    seg7 = 7'h39;
      3'd2:    seg7 = 7'h5E;
      3'd3:    seg7 = 7'h79;
      3'd4:    seg7 = 7'h71;
      3'd5:    seg7 = 7'h3D;
      3'd6:    seg7 = 7'h77;
      3'd7:    seg7 = 7'h7C;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // r_armed blocks a take on the first edge after reset, so an ok already high is absorbed by r_ok_q
  assign w_take = ok & ~r_ok_q & r_armed;

  // Expected pattern notes at the current index
  always_comb begin
    w_note_adj  = PAT_ADJ[2:0];
    w_note_comp = PAT_COMP[2:0];
    w_note_adv  = PAT_ADV[2:0];
    for (int k = 1; k < int'(LEN); k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_note_adj  = PAT_ADJ[3*k +: 3];
        w_note_comp = PAT_COMP[3*k +: 3];
        w_note_adv  = PAT_ADV[3*k +: 3];
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_match_nxt   = r_match;
    w_tom_nxt     = r_tom;
    w_display_nxt = r_display;
    w_fim_nxt     = 1'b0;
    w_tipo_nxt    = 2'b00;
`ifdef TP_TIMEOUT_EN
    w_cnt_nxt     = '0;
`endif

    if (w_take) begin
      w_display_nxt = seg7(nota);
      if (r_state != S_COLLECT) begin
        w_match_nxt = {nota == PAT_ADV[2:0], nota == PAT_COMP[2:0], nota == PAT_ADJ[2:0]};
        w_tom_nxt   = tom;
        w_idx_nxt   = IDX_W'(1);
        if (nota == 3'd0 || w_match_nxt == 3'b000) w_state_nxt = S_ERROR;
        else                                       w_state_nxt = S_COLLECT;
      end else begin
        w_match_nxt = r_match & {nota == w_note_adv, nota == w_note_comp, nota == w_note_adj};
        w_idx_nxt   = r_idx + IDX_W'(1);
        if (nota == 3'd0 || tom != r_tom || w_match_nxt == 3'b000) w_state_nxt = S_ERROR;
        else if (w_idx_nxt == IDX_W'(LEN))                        w_state_nxt = S_DONE;
      end
    end

`ifdef TP_TIMEOUT_EN
    // A take in the same cycle as expiry wins because the counter only runs without a take
    if (r_state == S_COLLECT && !w_take) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
      if (w_cnt_nxt == CNT_W'(TIMEOUT)) begin
        w_state_nxt = S_ERROR;
        w_cnt_nxt   = '0;
      end
    end
`endif

    w_fim_nxt = (w_state_nxt == S_DONE) || (w_state_nxt == S_ERROR);
    if (w_state_nxt == S_DONE) begin
      if      (w_match_nxt[0]) w_tipo_nxt = 2'b01;
      else if (w_match_nxt[1]) w_tipo_nxt = 2'b10;
      else                     w_tipo_nxt = 2'b11;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_ok_q    <= 1'b0;
      r_armed   <= 1'b0;
      r_idx     <= '0;
      r_match   <= 3'b000;
      r_tom     <= 1'b0;
      r_fim     <= 1'b0;
      r_tipo    <= 2'b00;
      r_display <= 7'h00;
`ifdef TP_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_ok_q    <= ok;
      r_armed   <= 1'b1;
      r_idx     <= w_idx_nxt;
      r_match   <= w_match_nxt;
      r_tom     <= w_tom_nxt;
      r_fim     <= w_fim_nxt;
      r_tipo    <= w_tipo_nxt;
      r_display <= w_display_nxt;
`ifdef TP_TIMEOUT_EN
      r_cnt     <= w_cnt_nxt;
`endif
    end
  end

  assign fim     = r_fim;
  assign tipo    = r_tipo;
  assign display = r_display;

endmodule
